inst_fetch_unit: RTL and testbench

- Decoupled instruction-fetch front end for the RV32I core.
- Sits directly upstream of decode. It owns the PC and issues word requests to a variable-latency instruction memory over a valid/ready request channel plus a valid-only in-order response channel.
- Buffers returned instructions with their PCs in a small FIFO, presented to decode on a valid/ready interface.
- Accepts branch/jump redirects from execute and discards all in-flight wrong-path fetches.

---
 rtl/inst_fetch_unit_pkg.sv | 20 ++
 rtl/inst_fetch_unit_sync_fifo.sv | 63 ++++++
 rtl/inst_fetch_unit.sv | 109 ++++++++++
 tb/tb_inst_fetch_unit.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: defaults,
// fetch-state encoding and the buffered fetch-entry layout.
package inst_fetch_unit_pkg;

  localparam int          FETCH_XLEN       = 32;
  localparam int          FETCH_FIFO_DEPTH = 4;
  localparam logic [31:0] FETCH_RESET_PC   = 32'h0000_0000;

  // RUN: normal fetching. FLUSH: wrong-path responses still owed by memory.
  typedef enum logic [1:0] {
    FS_RUN   = 2'd0,
    FS_FLUSH = 2'd1
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_sync_fifo.sv
// Registered synchronous FIFO with occupancy count and flush; the head entry
// is only visible the cycle after it was written (no write-to-read bypass).
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]             r_wr_ptr;
  logic [AW-1:0]             r_rd_ptr;
  logic [CW-1:0]             r_count;
  logic [DEPTH-1:0][WIDTH-1:0] w_entry;
  logic                      w_pop;
  logic                      w_push;

  // A push into a full FIFO is accepted only when the head leaves this cycle.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] r_entry;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_entry <= '0;
        end else if (w_push && !i_flush && (r_wr_ptr == AW'(gi))) begin
          r_entry <= i_data;
        end
      end
      assign w_entry[gi] = r_entry;
    end
  endgenerate

  assign o_data  = w_entry[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// Decoupled RV32I fetch front end: owns the PC, issues credit-limited word
// fetches, buffers responses with their PCs and discards wrong-path returns.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = FETCH_XLEN,
  parameter int                    FIFO_DEPTH = FETCH_FIFO_DEPTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = FETCH_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0]   r_fetch_pc;
  logic [DATA_WIDTH-1:0]   r_resp_pc;
  logic [CW-1:0]           r_outstanding;
  logic [CW-1:0]           r_discard;
  fetch_state_e            r_state;

  logic [CW-1:0]           w_fifo_count;
  logic [CW:0]             w_credit_used;
  logic                    w_req_fire;
  logic                    w_push;
  logic [CW-1:0]           w_outstanding_next;
  logic [CW-1:0]           w_discard_next;
  logic [DATA_WIDTH-1:0]   w_target;
  logic [2*DATA_WIDTH-1:0] w_head;
  logic                    w_unused;

  // Buffered plus in-flight never exceeds the FIFO size, so every response has a slot.
  assign w_credit_used  = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
  assign imem_req_valid = !rst && !redirect && (w_credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_push             = imem_resp_valid && (r_discard == '0) && !redirect;
  assign w_outstanding_next = r_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid);
  assign w_target           = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
  assign w_unused           = ^redirect_pc[1:0];

  always_comb begin
    w_discard_next = r_discard;
    if (redirect) begin
      w_discard_next = w_outstanding_next;
    end else if (imem_resp_valid && (r_discard != '0)) begin
      w_discard_next = r_discard - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_state       <= FS_RUN;
    end else begin
      r_outstanding <= w_outstanding_next;
      r_discard     <= w_discard_next;
      r_state       <= (w_discard_next != '0) ? FS_FLUSH : FS_RUN;
      if (redirect) begin
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(4);
        if (w_push)     r_resp_pc  <= r_resp_pc + DATA_WIDTH'(4);
      end
    end
  end

  sync_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect),
    .i_push  (w_push),
    .i_data  ({r_resp_pc, imem_resp_data}),
    .i_pop   (inst_ready),
    .o_valid (inst_valid),
    .o_data  (w_head),
    .o_count (w_fifo_count)
  );

  assign inst    = w_head[DATA_WIDTH-1:0];
  assign inst_pc = w_head[2*DATA_WIDTH-1:DATA_WIDTH];

  // A response with nothing in flight means the memory side lost sync with us.
  a_no_stray_resp: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (r_outstanding != '0));

  a_credit_bounds: assert property (@(posedge clk) disable iff (rst)
    (r_discard <= r_outstanding) && (r_outstanding <= CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat_min = 1, lat_max = 1, rdy_pct = 100, ird_pct = 100;
  int          outst = 0, n_req = 0, n_pop = 0;
  int          first_req_cyc = -1, first_valid_cyc = -1;
  logic [31:0] exp_pc = 32'h0, exp_req_pc = 32'h0;
  logic [31:0] first_after = 32'h0;
  bit          got_after = 0;
  bit          nop_mode = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (nop_mode) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // One cycle: drive memory/consumer/redirect, check against the path model, advance.
  task automatic step(input bit do_redir, input logic [31:0] tgt);
    imem_req_ready = (int'($urandom_range(99)) < rdy_pct);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    redirect    = do_redir;
    redirect_pc = do_redir ? tgt : $urandom;
    inst_ready  = (int'($urandom_range(99)) < ird_pct);
    #1;
    if (do_redir) begin
      checks++;
      if (imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL req_during_redirect got %b want 0", imem_req_valid);
      end
    end
    if (imem_req_valid === 1'b1 && imem_req_ready) begin
      checks++;
      if (imem_req_addr !== exp_req_pc) begin
        errors++;
        $display("FAIL req_addr got %h want %h", imem_req_addr, exp_req_pc);
      end
      pend.push_back('{addr: imem_req_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
      exp_req_pc += 32'd4;
      outst++;
      n_req++;
      if (first_req_cyc < 0) first_req_cyc = cyc;
      checks++;
      if (outst > 4) begin
        errors++;
        $display("FAIL credit_limit got %0d outstanding want <= 4", outst);
      end
    end
    if (imem_resp_valid) begin
      void'(pend.pop_front());
      outst--;
    end
    if (inst_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (inst_valid === 1'b1 && inst_ready) begin
      checks++;
      if (inst_pc !== exp_pc) begin
        errors++;
        $display("FAIL inst_pc got %h want %h", inst_pc, exp_pc);
      end
      checks++;
      if (inst !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL inst_data at %h got %h want %h", exp_pc, inst, mem_word(exp_pc));
      end
      if (!got_after) begin
        first_after = inst_pc;
        got_after   = 1;
      end
      exp_pc += 32'd4;
      n_pop++;
    end
    if (do_redir) begin
      exp_pc     = {tgt[31:2], 2'b00};
      exp_req_pc = {tgt[31:2], 2'b00};
      got_after  = 0;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  task automatic apply_reset();
    rst = 1'b1; imem_resp_valid = 1'b0; redirect = 1'b0;
    inst_ready = 1'b0; imem_req_ready = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL req_valid_in_reset got %b want 0", imem_req_valid);
    end
    @(posedge clk); @(negedge clk); cyc++;
    checks++;
    if ({inst_valid, imem_req_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_valids got %b want 00", {inst_valid, imem_req_valid});
    end
    checks++;
    if (inst !== 32'h0 || inst_pc !== 32'h0) begin
      errors++; $display("FAIL reset_head got %h/%h want 0/0", inst, inst_pc);
    end
    pend.delete();
    outst = 0; n_req = 0; n_pop = 0; got_after = 0;
    first_req_cyc = -1; first_valid_cyc = -1;
    exp_pc = 32'h0; exp_req_pc = 32'h0;
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++; $display("FAIL restart_req got %b@%h want 1@00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic wait_outst(input int target);
    int budget = 40;
    while (outst != target && budget > 0) begin
      step(1'b0, 32'h0);
      budget--;
    end
    checks++;
    if (outst != target) begin
      errors++; $display("FAIL outstanding_wait got %0d want %0d", outst, target);
    end
  endtask

  task automatic check_first_after(input logic [31:0] want);
    int budget = 60;
    while (!got_after && budget > 0) begin
      step(1'b0, 32'h0);
      budget--;
    end
    checks++;
    if (!got_after || first_after !== want) begin
      errors++; $display("FAIL first_pc_after_redirect got %h (seen %0d) want %h", first_after, got_after, want);
    end
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_zero_wait();
    nop_mode = 1; lat_min = 1; lat_max = 1; rdy_pct = 100; ird_pct = 100;
    apply_reset();
    run(30);
    checks++;
    if (first_valid_cyc - first_req_cyc != 2) begin
      errors++; $display("FAIL first_valid_latency got %0d want 2", first_valid_cyc - first_req_cyc);
    end
    checks++;
    if (n_pop != 28) begin
      errors++; $display("FAIL zero_wait_throughput got %0d want 28", n_pop);
    end
    nop_mode = 0;
  endtask

  task automatic test_backpressure();
    lat_min = 1; lat_max = 1; rdy_pct = 100; ird_pct = 0;
    apply_reset();
    run(20);
    checks++;
    if (n_req != 4) begin
      errors++; $display("FAIL stalled_requests got %0d want 4", n_req);
    end
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL stalled_req_valid got %b want 0", imem_req_valid);
    end
    checks++;
    if (dut.w_fifo_count !== 3'd4) begin
      errors++; $display("FAIL stalled_fifo_count got %0d want 4", dut.w_fifo_count);
    end
    ird_pct = 100;
    run(20);
    checks++;
    if (n_pop < 16) begin
      errors++; $display("FAIL drain_after_stall got %0d want >= 16", n_pop);
    end
  endtask

  task automatic test_redirect_flush();
    lat_min = 3; lat_max = 3; rdy_pct = 100; ird_pct = 100;
    apply_reset();
    wait_outst(3);
    step(1'b1, 32'h0000_0100);
    checks++;
    if (dut.r_discard !== 3'(outst)) begin
      errors++; $display("FAIL flush_discard got %0d want %0d", dut.r_discard, outst);
    end
    check_first_after(32'h0000_0100);
    run(20);
  endtask

  task automatic test_redirect_collision();
    int budget = 60;
    lat_min = 2; lat_max = 4; rdy_pct = 100; ird_pct = 100;
    apply_reset();
    while (!(outst >= 2 && pend.size() > 0 && pend[0].due <= cyc) && budget > 0) begin
      step(1'b0, 32'h0);
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++; $display("FAIL collision_setup got timeout want response with >=2 outstanding");
    end
    step(1'b1, 32'h0000_0203);
    checks++;
    if (dut.r_discard !== 3'(outst)) begin
      errors++; $display("FAIL collision_discard got %0d want %0d", dut.r_discard, outst);
    end
    checks++;
    if (imem_req_addr !== 32'h0000_0200) begin
      errors++; $display("FAIL aligned_target got %h want 00000200", imem_req_addr);
    end
    check_first_after(32'h0000_0200);
    run(10);
  endtask

  task automatic test_back_to_back();
    lat_min = 1; lat_max = 4; rdy_pct = 80; ird_pct = 80;
    apply_reset();
    run(8);
    step(1'b1, 32'h0000_0040);
    step(1'b1, 32'h0000_0080);
    checks++;
    if (dut.r_discard !== 3'(outst)) begin
      errors++; $display("FAIL b2b_discard got %0d want %0d", dut.r_discard, outst);
    end
    check_first_after(32'h0000_0080);
    run(20);
  endtask

  task automatic test_reset_midstream();
    lat_min = 3; lat_max = 3; rdy_pct = 100; ird_pct = 100;
    apply_reset();
    wait_outst(2);
    apply_reset();
    run(20);
    checks++;
    if (n_pop == 0) begin
      errors++; $display("FAIL restart_after_reset got %0d pops want > 0", n_pop);
    end
  endtask

  task automatic test_random();
    lat_min = 1; lat_max = 5; rdy_pct = 60; ird_pct = 60;
    apply_reset();
    run(10);
    step(1'b1, 32'hFFFF_FFF6);
    check_first_after(32'hFFFF_FFF4);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 3) step(1'b1, $urandom);
      else step(1'b0, 32'h0);
    end
    checks++;
    if (n_pop < 200) begin
      errors++; $display("FAIL random_progress got %0d pops want >= 200", n_pop);
    end
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_redirect_flush();
    test_redirect_collision();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
